nibble_sub_seq: RTL and testbench

- Nibble-serial multi-word subtractor controller.
- Computes D = A - B on (4*NIBBLES)-bit unsigned/two's-complement operands.
- Reuses one 4-bit add slice (complement-and-add, carry held in a flop), one nibble per cycle, LSB nibble first.
- Sits between an operand producer and a result consumer; valid/ready handshakes on both sides; one operation in flight.

---
 rtl/nsub_pkg.sv | 8 +
 rtl/nibble_sub_seq_if.sv | 24 ++
 rtl/nsub_slice.sv | 16 +
 rtl/nibble_sub_seq.sv | 82 ++++++++
 tb/tb_nibble_sub_seq.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/nsub_pkg.sv
// nsub_pkg: shared types and helpers for the nibble-serial subtractor
package nsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int SLICE_W = 4;
    function automatic int nib_idx_w(input int nibbles);
        return (nibbles > 1) ? $clog2(nibbles) : 1;
    endfunction
endpackage

// File: rtl/nibble_sub_seq_if.sv
// nibble_sub_seq_if: operand and result handshakes of the nibble-serial subtractor
interface nibble_sub_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;
    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, diff, borrow, ovf, zero
    );
    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, diff, borrow, ovf, zero
    );
endinterface

// File: rtl/nsub_slice.sv
// nsub_slice: 4-bit ripple-carry adder slice with explicit carry-in
module nsub_slice (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [4:0] c;
    assign c[0] = cin;
    for (genvar g = 0; g < 4; g++) begin : g_fa
        assign s[g]   = a[g] ^ b[g] ^ c[g];
        assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
    end
    assign cout = c[4];
endmodule

// File: rtl/nibble_sub_seq.sv
// nibble_sub_seq: W-bit A-B computed one nibble per cycle through a single shared adder slice
module nibble_sub_seq
    import nsub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input logic             clk,
    input logic             rst_n,
    nibble_sub_seq_if.slave bus
);
    localparam int W  = SLICE_W * NIBBLES;
    localparam int IW = nib_idx_w(NIBBLES);
    state_t               state, state_nxt;
    logic [W-1:0]         a_q, b_q, diff_q, diff_nxt;
    logic [IW-1:0]        idx;
    logic [IW+1:0]        base;
    logic [SLICE_W-1:0]   a_nib, b_nib, sum;
    logic                 carry, cout, last, borrow_q, ovf_q, zero_q;
    assign base  = {idx, 2'b00};
    assign a_nib = a_q[base +: SLICE_W];
    assign b_nib = ~b_q[base +: SLICE_W];
    assign last  = idx == IW'(NIBBLES - 1);
    nsub_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (sum),
        .cout (cout)
    );
    // flags are taken on the final RUN edge, so they must see the top nibble being written
    always_comb begin
        diff_nxt = diff_q;
        diff_nxt[base +: SLICE_W] = sum;
    end
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.in_valid ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = bus.out_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            idx      <= '0;
            carry    <= 1'b1;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && bus.in_valid) begin
                a_q    <= bus.a_in;
                b_q    <= bus.b_in;
                diff_q <= '0;
                idx    <= '0;
                carry  <= 1'b1;
            end
            if (state == RUN) begin
                diff_q <= diff_nxt;
                carry  <= cout;
                idx    <= last ? '0 : idx + 1'b1;
                if (last) begin
                    borrow_q <= ~cout;
                    ovf_q    <= (a_q[W-1] != b_q[W-1]) && (diff_nxt[W-1] != a_q[W-1]);
                    zero_q   <= diff_nxt == '0;
                end
            end
        end
    end
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_nibble_sub_seq.sv
// tb_nibble_sub_seq: directed vectors for the nibble-serial subtractor, NIBBLES=4
module tb_nibble_sub_seq;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    nibble_sub_seq_if #(.NIBBLES(4)) bus ();
    nibble_sub_seq #(.NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ed,
                         input logic eb, input logic eo, input logic ez, input string nm);
        int cyc;
        cyc = 0;
        while (!bus.in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (bus.in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s in_ready got %b exp 1", nm, bus.in_ready);
        end
        bus.a_in = a;
        bus.b_in = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a_in = ~a;
        bus.b_in = a ^ b ^ 16'h5a5a;
        cyc = 0;
        while (!bus.out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        vectors++;
        if (cyc !== 4) begin
            miscompares++;
            $display("FAIL %s latency got %0d exp 4", nm, cyc);
        end
        vectors++;
        if (bus.diff !== ed) begin
            miscompares++;
            $display("FAIL %s diff got %h exp %h", nm, bus.diff, ed);
        end
        vectors++;
        if ({bus.borrow, bus.ovf, bus.zero} !== {eb, eo, ez}) begin
            miscompares++;
            $display("FAIL %s borrow/ovf/zero got %b%b%b exp %b%b%b", nm,
                     bus.borrow, bus.ovf, bus.zero, eb, eo, ez);
        end
        vectors++;
        if (bus.in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s in_ready_done got %b exp 0", nm, bus.in_ready);
        end
        if (bus.out_ready) begin
            @(negedge clk);
            vectors++;
            if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
                miscompares++;
                $display("FAIL %s after_handshake out_valid/in_ready got %b%b exp 01", nm,
                         bus.out_valid, bus.in_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero} !== {2'b10, 16'h0, 3'b000}) begin
            miscompares++;
            $display("FAIL reset outputs got %b%b %h %b%b%b exp 10 0000 000", bus.in_ready,
                     bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_arith();
        do_op(16'h1234, 16'h0235, 16'h0FFF, 1'b0, 1'b0, 1'b0, "sub_basic");
        do_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0, "sub_wrap");
        do_op(16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0, "ovf_neg");
        do_op(16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0, "ovf_pos");
        do_op(16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1, "zero");
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        do_op(16'h1234, 16'h0235, 16'h0FFF, 1'b0, 1'b0, 1'b0, "bp_op");
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = (i == 3);
            bus.a_in = 16'hFFFF;
            bus.b_in = 16'h0000;
            @(negedge clk);
            vectors++;
            if ({bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.ovf, bus.zero} !== {2'b10, 16'h0FFF, 3'b000}) begin
                miscompares++;
                $display("FAIL bp_hold cycle %0d got %b%b %h %b%b%b exp 10 0fff 000", i,
                         bus.out_valid, bus.in_ready, bus.diff, bus.borrow, bus.ovf, bus.zero);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release out_valid/in_ready got %b%b exp 01", bus.out_valid, bus.in_ready);
        end
        do_op(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, "bp_next");
    endtask

    task automatic test_reset_mid_run();
        bus.a_in = 16'h1234;
        bus.b_in = 16'h0235;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.in_ready, bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero} !== {2'b10, 16'h0, 3'b000}) begin
            miscompares++;
            $display("FAIL mid_reset outputs got %b%b %h %b%b%b exp 10 0000 000", bus.in_ready,
                     bus.out_valid, bus.diff, bus.borrow, bus.ovf, bus.zero);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_arith();
        test_backpressure();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
